// File: rtl/uart_tx_cfg_pkg.sv
// Shared types, constants and parity helper for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    typedef enum logic [1:0] {
        ParNone = 2'b00,
        ParEven = 2'b01,
        ParOdd  = 2'b10
    } uart_parity_e;

    localparam int unsigned UART_MIN_DBITS = 5;
    localparam int unsigned UART_DATA_W    = 16;

    // Parity over data[dbits-1:0] only; odd=1 inverts the result.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic [3:0]             dbits,
                                         input logic                   odd);
        logic p;
        p = odd;
        for (int i = 0; i < int'(UART_DATA_W); i++) begin
            if (i < int'(dbits)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Ready/valid word interface between the transmit FIFO and the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned MAX_DBITS = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [MAX_DBITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: data length, parity and stop bits are
// latched per word at accept time; bit timing is paced by an external sample tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DBITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sample_tick,
    uart_tx_cfg_if.slave s_if,
    input  logic [3:0]   cfg_dbits,
    input  logic [1:0]   cfg_parity,
    input  logic         cfg_stop2,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         tx
);

    localparam int unsigned      CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DBITS_MIN = 4'(UART_MIN_DBITS);
    localparam logic [3:0]       DBITS_MAX = 4'(MAX_DBITS);

    uart_state_e          r_state, w_state_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic [3:0]           r_idx, w_idx_d;
    logic [MAX_DBITS-1:0] r_data, w_data_d;
    logic                 r_stop_second, w_stop_second_d;
    logic [3:0]           r_dbits;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_stop2;
    logic                 r_tx, w_tx_d;

    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_done;
    logic [3:0]           w_dbits_clamp;

    assign s_if.s_ready = (r_state == StIdle) & reset_n;
    assign w_accept     = s_if.s_valid & s_if.s_ready;
    assign w_bit_end    = sample_tick & (r_cnt == CNT_LAST);

    always_comb begin
        if (cfg_dbits < DBITS_MIN) begin
            w_dbits_clamp = DBITS_MIN;
        end else if (cfg_dbits > DBITS_MAX) begin
            w_dbits_clamp = DBITS_MAX;
        end else begin
            w_dbits_clamp = cfg_dbits;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_idx_d         = r_idx;
        w_data_d        = r_data;
        w_stop_second_d = r_stop_second;
        w_done          = 1'b0;

        // Counter restarts at every bit boundary, which also covers each state entry.
        if ((r_state != StIdle) && sample_tick) begin
            w_cnt_d = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (w_accept) begin
                    w_state_d       = StStart;
                    w_data_d        = s_if.s_data;
                    w_stop_second_d = 1'b0;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_state_d = StData;
                    w_idx_d   = '0;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_data_d = r_data >> 1;
                    if (r_idx == (r_dbits - 1'b1)) begin
                        w_state_d = r_par_en ? StParity : StStop;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_stop_second_d = 1'b1;
                    end else begin
                        w_done    = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so tx is registered yet aligned to it.
    always_comb begin
        unique case (w_state_d)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_data_d[0];
            StParity: w_tx_d = r_par_bit;
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_data        <= '0;
            r_stop_second <= 1'b0;
            r_dbits       <= DBITS_MIN;
            r_par_en      <= 1'b0;
            r_par_bit     <= 1'b0;
            r_stop2       <= 1'b0;
            r_tx          <= 1'b1;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_idx         <= w_idx_d;
            r_data        <= w_data_d;
            r_stop_second <= w_stop_second_d;
            r_tx          <= w_tx_d;
            if (w_accept) begin
                r_dbits   <= w_dbits_clamp;
                r_par_en  <= (cfg_parity == ParEven) || (cfg_parity == ParOdd);
                r_par_bit <= uart_parity(UART_DATA_W'(s_if.s_data), w_dbits_clamp,
                                         cfg_parity == ParOdd);
                r_stop2   <= cfg_stop2;
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != StIdle);
    assign tx_done = w_done & reset_n;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: one 8-bit/16x instance with a divided tick and
// one 9-bit/2x instance ticked every clock; frames are decoded from the line.
module tb_uart_tx_cfg;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       tick_a = 1'b0;
    logic       tick_b;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       busy_a, done_a, tx_a;
    logic       busy_b, done_b, tx_b;

    uart_tx_cfg_if #(.MAX_DBITS(8)) if_a ();
    uart_tx_cfg_if #(.MAX_DBITS(9)) if_b ();

    uart_tx_cfg #(.MAX_DBITS(8), .OVERSAMPLE(16)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_tick(tick_a),
        .s_if       (if_a),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_busy    (busy_a),
        .tx_done    (done_a),
        .tx         (tx_a)
    );

    uart_tx_cfg #(.MAX_DBITS(9), .OVERSAMPLE(2)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_tick(tick_b),
        .s_if       (if_b),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_busy    (busy_b),
        .tx_done    (done_b),
        .tx         (tx_b)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     tdiv = 0;
    int     sel = 0;
    int     acc_cyc = 0;
    int     done_cyc = 0;
    int     mon_ticks = 0;
    int     mon_glitch = 0;
    logic   mon_after_done = 1'b0;
    logic [31:0] mon_bits = '0;
    frame_t sb[$];

    logic m_tx, m_busy, m_done, m_tick, m_ready;
    int   os;
    assign m_tx    = (sel == 1) ? tx_b : tx_a;
    assign m_busy  = (sel == 1) ? busy_b : busy_a;
    assign m_done  = (sel == 1) ? done_b : done_a;
    assign m_tick  = (sel == 1) ? tick_b : tick_a;
    assign m_ready = (sel == 1) ? if_b.s_ready : if_a.s_ready;
    assign os      = (sel == 1) ? 2 : 16;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tdiv   <= (tdiv == 2) ? 0 : tdiv + 1;
        tick_a <= (tdiv == 2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t model(input logic [8:0] d, input logic [3:0] cd,
                                     input logic [1:0] par, input logic st2, input int maxd);
        frame_t f;
        int     n;
        int     k;
        logic   p;
        n = (int'(cd) < 5) ? 5 : ((int'(cd) > maxd) ? maxd : int'(cd));
        f.bits = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (par == 2'b01 || par == 2'b10) begin
            f.bits[k] = p ^ (par == 2'b10);
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (st2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.nbits = k;
        return f;
    endfunction

    // Line monitor: one sample per tick while busy, grouped into bits of os ticks.
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_ticks      = 0;
            mon_glitch     = 0;
            mon_bits       = '0;
            mon_after_done = 1'b0;
        end else begin
            if (mon_after_done) begin
                check_eq("ready_after_done", {31'd0, m_ready}, 32'd1);
                check_eq("idle_after_done", {31'd0, m_busy}, 32'd0);
                mon_after_done = 1'b0;
            end
            if (m_busy && m_tick) begin
                if ((mon_ticks / os) < 32) begin
                    if ((mon_ticks % os) == 0) begin
                        mon_bits[mon_ticks / os] = m_tx;
                    end else if (m_tx !== mon_bits[mon_ticks / os]) begin
                        mon_glitch++;
                    end
                end
                mon_ticks++;
            end
            if (m_done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", {31'd0, m_done}, 32'd0);
                end else begin
                    frame_t e;
                    e = sb.pop_front();
                    check_eq("frame_ticks", mon_ticks, e.nbits * os);
                    check_eq("frame_bits", mon_bits, e.bits);
                    check_eq("bit_stable", mon_glitch, 0);
                end
                mon_ticks      = 0;
                mon_glitch     = 0;
                mon_bits       = '0;
                done_cyc       = cyc;
                mon_after_done = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [8:0] d, input logic [3:0] cd, input logic [1:0] par,
                        input logic st2);
        int n = 0;
        cfg_dbits  = cd;
        cfg_parity = par;
        cfg_stop2  = st2;
        if (sel == 1) begin
            if_b.s_valid = 1'b1;
            if_b.s_data  = d;
        end else begin
            if_a.s_valid = 1'b1;
            if_a.s_data  = d[7:0];
        end
        while (!m_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            check_eq("accept_timeout", {31'd0, m_ready}, 32'd1);
        end
        sb.push_back(model(d, cd, par, st2, (sel == 1) ? 9 : 8));
        acc_cyc = cyc;
        @(negedge clk);
        if_a.s_valid = 1'b0;
        if_b.s_valid = 1'b0;
        check_eq("tx_start_low", {31'd0, m_tx}, 32'd0);
        check_eq("busy_in_start", {31'd0, m_busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || m_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("idle_timeout", sb.size(), 0);
        end
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        tick_b       = 1'b1;
        if_a.s_valid = 1'b0;
        if_a.s_data  = '0;
        if_b.s_valid = 1'b0;
        if_b.s_data  = '0;
        cfg_dbits    = 4'd8;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_ready", {31'd0, if_a.s_ready}, 32'd0);
        check_eq("rst_ready_b", {31'd0, if_b.s_ready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {31'd0, if_a.s_ready}, 32'd1);

        send(9'h055, 4'd8, 2'b00, 1'b0); wait_idle();   // 8N1
        send(9'h03A, 4'd7, 2'b01, 1'b1); wait_idle();   // 7E2
        send(9'h0A5, 4'd8, 2'b10, 1'b0); wait_idle();   // 8O1
        send(9'h0F3, 4'd3, 2'b11, 1'b0); wait_idle();   // clamp to 5, parity 11 = none
        send(9'h0C6, 4'd12, 2'b01, 1'b0); wait_idle();  // clamp to 8

        // Backpressure with mid-frame config change
        send(9'h081, 4'd8, 2'b00, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("ready_mid_frame", {31'd0, if_a.s_ready}, 32'd0);
        send(9'h02C, 4'd6, 2'b01, 1'b1);
        check_eq("b2b_accept_gap", acc_cyc - done_cyc, 1);
        wait_idle();

        // Reset during data bit 3
        send(9'h0B4, 4'd8, 2'b01, 1'b0);
        n = 0;
        while (mon_ticks < 70 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_bit3", {31'd0, mon_ticks >= 70}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done_a}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, if_a.s_ready}, 32'd0);
        reset_n = 1'b1;
        if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        @(negedge clk);
        check_eq("ready_after_mid_rst", {31'd0, if_a.s_ready}, 32'd1);
        send(9'h0C3, 4'd8, 2'b00, 1'b0); wait_idle();

        // Tick on every clock, 9-bit words
        sel = 1;
        @(negedge clk);
        send(9'h1FF, 4'd9, 2'b00, 1'b0); wait_idle();   // 9N1
        send(9'h0A3, 4'd12, 2'b00, 1'b1); wait_idle();  // clamp to 9
        send(9'h00F, 4'd8, 2'b01, 1'b0);
        send(9'h155, 4'd3, 2'b10, 1'b1);                // 5O2 back-to-back
        check_eq("b2b_gap_fast", acc_cyc - done_cyc, 1);
        wait_idle();

        repeat (4) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
